// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: parametrised signed multiply-accumulate with optional multiplier pipelining,
// saturate/wrap accumulation, per-sample clear and a sticky overflow flag.
module mac_pipe_acc #(
    parameter int W    = 12,
    parameter int AW   = 24,
    parameter int PIPE = 0,
    parameter int SAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    input  logic                 valid_in,
    input  logic                 clear_acc,
    output logic signed [AW-1:0] f,
    output logic                 valid_out,
    output logic                 ovf
);
    localparam logic [AW-1:0] F_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] F_MIN = {1'b1, {(AW-1){1'b0}}};

    logic signed [W-1:0]   a_q, b_q;
    logic                  clr_q, v0;
    logic signed [2*W-1:0] mul;
    logic signed [AW-1:0]  prod, p_fin, base;
    logic                  c_fin, v_fin, of;
    logic [AW:0]           sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            clr_q <= 1'b0;
            v0    <= 1'b0;
        end else begin
            v0 <= valid_in;
            if (valid_in) begin
                a_q   <= a;
                b_q   <= b;
                clr_q <= clear_acc;
            end
        end
    end

    assign mul  = (2*W)'(a_q) * (2*W)'(b_q);
    assign prod = AW'(mul);

    generate
        if (PIPE == 0) begin : g_comb
            assign p_fin = prod;
            assign c_fin = clr_q;
            assign v_fin = v0;
        end else begin : g_pipe
            logic signed [AW-1:0] p_r [1:PIPE];
            logic                 c_r [1:PIPE];
            logic                 v_r [1:PIPE];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 1; i <= PIPE; i++) begin
                        p_r[i] <= '0;
                        c_r[i] <= 1'b0;
                        v_r[i] <= 1'b0;
                    end
                end else begin
                    p_r[1] <= prod;
                    c_r[1] <= clr_q;
                    v_r[1] <= v0;
                    for (int i = 2; i <= PIPE; i++) begin
                        p_r[i] <= p_r[i-1];
                        c_r[i] <= c_r[i-1];
                        v_r[i] <= v_r[i-1];
                    end
                end
            end
            assign p_fin = p_r[PIPE];
            assign c_fin = c_r[PIPE];
            assign v_fin = v_r[PIPE];
        end
    endgenerate

    // One guard bit: overflow shows as disagreement between the top two sum bits.
    assign base = c_fin ? '0 : f;
    assign sum  = {base[AW-1], base} + {p_fin[AW-1], p_fin};
    assign of   = sum[AW] ^ sum[AW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f         <= '0;
            valid_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            valid_out <= v_fin;
            if (v_fin) begin
                f   <= (SAT != 0 && of) ? (sum[AW] ? F_MIN : F_MAX) : sum[AW-1:0];
                ovf <= (!c_fin && ovf) | of;
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe_acc.sv
// tb_mac_pipe_acc: four configurations driven in parallel, scoreboarded against an integer model.
module tb_mac_pipe_acc;
    typedef struct {
        int                 due;
        logic signed [23:0] f;
        logic               ovf;
    } exp_t;

    localparam longint F_MAX = 64'sd8388607;
    localparam longint F_MIN = -64'sd8388608;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic signed [11:0]       a = '0, b = '0;
    logic                     valid_in = 1'b0, clear_acc = 1'b0;
    logic signed [23:0]       fo [4];
    logic                     vo [4], oo [4];

    int     pipes [4] = '{0, 2, 3, 0};
    int     sats  [4] = '{1, 1, 1, 0};
    exp_t   q [4][$];
    longint acc [4];
    logic   mov [4];
    logic signed [23:0] last_f [4];
    logic   last_o [4];
    int     cyc = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;

    mac_pipe_acc #(.W(12), .AW(24), .PIPE(0), .SAT(1)) d0 (.clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_acc(clear_acc), .f(fo[0]), .valid_out(vo[0]), .ovf(oo[0]));
    mac_pipe_acc #(.W(12), .AW(24), .PIPE(2), .SAT(1)) d2 (.clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_acc(clear_acc), .f(fo[1]), .valid_out(vo[1]), .ovf(oo[1]));
    mac_pipe_acc #(.W(12), .AW(24), .PIPE(3), .SAT(1)) d3 (.clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_acc(clear_acc), .f(fo[2]), .valid_out(vo[2]), .ovf(oo[2]));
    mac_pipe_acc #(.W(12), .AW(24), .PIPE(0), .SAT(0)) dw (.clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_acc(clear_acc), .f(fo[3]), .valid_out(vo[3]), .ovf(oo[3]));

    task automatic chk(input string tag, input int idx, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s[%0d] cyc=%0d got=%0d expected=%0d", tag, idx, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            acc[i] = 0;
            mov[i] = 1'b0;
            last_f[i] = '0;
            last_o[i] = 1'b0;
        end
    endtask

    task automatic push(input logic c, input int av, input int bv);
        longint s, w;
        logic   o;
        for (int i = 0; i < 4; i++) begin
            s = (c ? 64'sd0 : acc[i]) + longint'(av) * longint'(bv);
            o = (s > F_MAX) || (s < F_MIN);
            w = s & 64'hFFFFFF;
            if (w > F_MAX) w = w - 64'sd16777216;
            acc[i] = (sats[i] != 0) ? ((s > F_MAX) ? F_MAX : (s < F_MIN) ? F_MIN : s) : w;
            mov[i] = (c ? 1'b0 : mov[i]) | o;
            q[i].push_back('{cyc + 2 + pipes[i], 24'(acc[i]), mov[i]});
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic ev;
        for (int i = 0; i < 4; i++) begin
            while (q[i].size() > 0 && q[i][0].due < cyc) void'(q[i].pop_front());
            ev = (q[i].size() > 0) && (q[i][0].due == cyc);
            chk("valid_out", i, 32'(vo[i]), 32'(ev));
            if (ev) begin
                e = q[i].pop_front();
                last_f[i] = e.f;
                last_o[i] = e.ovf;
            end
            chk("f", i, 32'(fo[i]), 32'(last_f[i]));
            chk("ovf", i, 32'(oo[i]), 32'(last_o[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    task automatic step(input logic v, input logic c, input int av, input int bv);
        tick();
        #2;
        valid_in = v;
        clear_acc = c;
        a = 12'(av);
        b = 12'(bv);
        if (v) push(c, av, bv);
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        @(negedge clk);
        monitor();
        tick();
        #2 reset = 1'b1;
        @(negedge clk);
        monitor();
        // accumulate with clear, back-to-back
        step(1, 1, 3, 4);
        step(1, 0, -5, 6);
        idle(5);
        chk("acc_f", 0, 32'(fo[0]), -18);
        chk("acc_ovf", 0, 32'(oo[0]), 0);
        // bubble with garbage operands and a clear that must be ignored
        step(1, 1, 2, 2);
        step(0, 1, 99, -7);
        step(1, 0, 2, 2);
        idle(5);
        chk("bubble_f", 1, 32'(fo[1]), 8);
        // positive saturation / wrap, then step back off the rail
        step(1, 1, 2047, 2047);
        step(1, 0, 2047, 2047);
        step(1, 0, 2047, 2047);
        step(1, 0, -1, 1);
        idle(5);
        chk("psat_f", 0, 32'(fo[0]), 8388606);
        chk("psat_ovf", 0, 32'(oo[0]), 1);
        chk("wrap_f", 3, 32'(fo[3]), -4206590);
        chk("wrap_ovf", 3, 32'(oo[3]), 1);
        step(1, 1, 1, 1);
        idle(5);
        chk("wclr_f", 3, 32'(fo[3]), 1);
        chk("wclr_ovf", 3, 32'(oo[3]), 0);
        // negative saturation
        step(1, 1, -2048, 2047);
        step(1, 0, -2048, 2047);
        step(1, 0, -2048, 2047);
        idle(5);
        chk("nsat_f", 0, 32'(fo[0]), -8388608);
        chk("nsat_ovf", 0, 32'(oo[0]), 1);
        // reset with samples in flight
        step(1, 1, 5, 5);
        step(1, 0, 6, 6);
        tick();
        #2;
        valid_in = 1'b0;
        clear_acc = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_f", i, 32'(fo[i]), 0);
            chk("rst_valid", i, 32'(vo[i]), 0);
            chk("rst_ovf", i, 32'(oo[i]), 0);
        end
        model_reset();
        @(negedge clk);
        monitor();
        tick();
        #2 reset = 1'b1;
        @(negedge clk);
        monitor();
        idle(6);
        step(1, 1, 7, 3);
        idle(6);
        chk("post_rst_f", 2, 32'(fo[2]), 21);
        chk("drained", 0, q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_pipe_acc.md
Name: mac_pipe_acc

Overview:
Parametrised pipelined signed multiply-accumulate unit, the successor to the fixed 12-bit MAC. It adds configurable operand and accumulator widths, optional multiplier pipelining, and a selectable saturate or wrap mode. It also adds a per-sample accumulator clear and a sticky overflow flag. It sits in the datapath between the operand-fetch control and the result writeback, one instance per output channel.

Parameters:
W, 12, signed operand width of a and b
AW, 24, accumulator/output width; must be >= 2*W
PIPE, 0, number of registered multiplier stages between operand register and accumulator (0..3)
SAT, 1, 1 = saturate on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
a  in  W  signed operand A
b  in  W  signed operand B
valid_in  in  1  a/b (and clear_acc) valid this cycle
clear_acc  in  1  sampled with valid_in; this sample starts a new accumulation
f  out  AW  signed accumulator value
valid_out  out  1  f updated by a sample this cycle
ovf  out  1  sticky: an overflow occurred since the last clear

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers, f, valid_out and ovf are forced to 0 immediately. No output changes until the first clk edge after reset deasserts.
- Operand stage: a, b and clear_acc are captured at an edge where valid_in=1. Otherwise they hold their values. A valid bit v0 is captured as valid_in on every edge.
- Multiplier: full signed product of width 2*W, sign-extended to AW.
  - PIPE=0: the product is combinational from the operand stage.
  - PIPE=N: N registers carry the product, clear flag and valid bit. They always shift, with no stall.
- Accumulator update at the edge where the final-stage valid is 1:
  - Sum: sum = (clear ? 0 : f) + product, computed in AW+1 bits.
  - Overflow: occurs when sum is outside [-2^(AW-1), 2^(AW-1)-1].
  - SAT=1: f <= 2^(AW-1)-1 on positive overflow, -2^(AW-1) on negative overflow, else sum.
  - SAT=0: f <= sum[AW-1:0].
  - ovf: ovf <= (clear ? 0 : ovf) | overflow. A clear with an overflowing product is impossible because AW >= 2W.
- When the final-stage valid is 0: f and ovf hold.
- valid_out is registered. It is 1 exactly in the cycle after the edge where f was updated by a sample, else 0.
- Latency: a sample presented with valid_in at edge k updates f at edge k+1+PIPE, with valid_out high during the following cycle. This matches the previous MAC when PIPE=0.
- Throughput: one sample per cycle. Back-to-back samples each accumulate exactly once.
- Bubbles (valid_in=0) propagate as idle slots. They never alter f, ovf or the held operands.
- clear_acc with valid_in=0 is ignored.
- Reset asserted mid-pipeline discards all in-flight samples. No valid_out is produced for them after release.
- Saturated f participates in later sums normally. Adding an opposite-sign product moves f back off the rail.

Test Plan:
- Accumulate (W=12, AW=24, PIPE=0, SAT=1): clear_acc=1 with a=3, b=4, then a=-5, b=6 back-to-back -> f=12 then f=-18, valid_out high both cycles, ovf=0.
- Latency and bubbles (PIPE=2): valid_in pattern 1,0,1 with a=b=2 (first with clear) -> f=4 exactly 3 edges after the first sample, f holds 4 during the bubble, f=8 after the third edge, valid_out pattern 1,0,1.
- Positive saturation (SAT=1): clear then a=b=2047 three times -> f=4190209, 8380418, then 8388607 with ovf=1. Then a=-1, b=1 -> f=8388606, ovf stays 1.
- Wrap mode (SAT=0): same stimulus -> third f=-4206589, ovf=1. A following clear_acc with a=1, b=1 -> f=1, ovf=0.
- Negative saturation (SAT=1): clear then a=-2048, b=2047 three times -> f=-4192256, -8384512, -8388608 with ovf=1.
- Reset mid-operation (PIPE=3): assert reset between clock edges while 2 samples are in flight -> f, valid_out, ovf go to 0 immediately. After release, no valid_out occurs until a new valid_in sample arrives 4 edges earlier.
